duty_sequencer: RTL and testbench
=================================

DUTY_SEQUENCER -- requirements
Module: duty_sequencer

Interface
REQ-001 The module SHALL have parameter NB_OUTPUTS, default 16, the number of PWM channels fed; legal range 2..256.
REQ-002 The module SHALL have parameter DUTY_WIDTH, default 8, the width of the duty word.
REQ-003 The module SHALL have parameter STEP_TICKS, default 100000, the clk cycles between frames; legal range >=2.
REQ-004 The module SHALL have parameter STEP, default 4, the phase increment per frame, range 0..2^(DUTY_WIDTH+1)-1.
REQ-005 The module SHALL have parameter PHASE_OFFSET, default 32, the phase added per channel index.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port run, input, 1 bit: high enables frame generation.
REQ-009 The module SHALL have port duty_ready, input, 1 bit: downstream accepts the current word.
REQ-010 The module SHALL have port duty_cycle, output, DUTY_WIDTH bits: the duty word.
REQ-011 The module SHALL have port duty_output, output, $clog2(NB_OUTPUTS) bits: the target channel index.
REQ-012 The module SHALL have port duty_valid, output, 1 bit: the word and index are valid.
REQ-013 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last word of a frame is accepted.

Function
REQ-015 Phase register P SHALL be DUTY_WIDTH+1 bits and wrap modulo 2^(DUTY_WIDTH+1).
REQ-016 Channel i phase SHALL be q = (P + i*PHASE_OFFSET) mod 2^(DUTY_WIDTH+1).
REQ-017 Duty word SHALL be the triangle map: q[MSB]=0 gives q[DUTY_WIDTH-1:0]; q[MSB]=1 gives the bitwise inverse of q[DUTY_WIDTH-1:0].
REQ-018 FSM states SHALL be IDLE, SEND and WAIT.
REQ-019 IDLE: when run is sampled high at an edge, the FSM SHALL move to SEND with channel index 0; duty_valid is high from the following cycle.
REQ-020 SEND: duty_valid SHALL stay high with duty_cycle and duty_output stable until duty_ready is sampled high (valid/ready handshake).
REQ-021 SEND: on each accept, the index SHALL advance by one; with duty_ready held high, N words are issued in N consecutive cycles.
REQ-022 Accept of index NB_OUTPUTS-1 SHALL deassert duty_valid on the next cycle and pulse frame_done for exactly 1 cycle.
REQ-023 After the last accept, the FSM SHALL go to WAIT when run is high, or to IDLE when run is low.
REQ-024 WAIT SHALL last exactly STEP_TICKS cycles; on exit P SHALL be updated to P+STEP and the FSM SHALL enter SEND at index 0.
REQ-025 run falling during SEND SHALL NOT abort the frame; the frame completes, then the FSM enters IDLE.
REQ-026 run falling during WAIT SHALL take the FSM to IDLE on the next edge, with P unchanged.
REQ-027 P SHALL be retained in IDLE; a restart resumes from the retained P.
REQ-028 STEP=0 SHALL be legal and yield identical frames.
REQ-029 duty_ready high outside SEND SHALL be ignored.
REQ-030 duty_valid SHALL NOT be asserted outside SEND.

Reset
REQ-031 While rst is low, the FSM SHALL be in IDLE.
REQ-032 While rst is low, P, the index and the tick counter SHALL be 0.
REQ-033 While rst is low, duty_valid, busy, frame_done, duty_cycle and duty_output SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL drop duty_valid immediately, with no completion of the frame.
REQ-035 Reset release SHALL be synchronous to clk; the first run sample occurs on the first edge after release.

Structure
REQ-036 Package duty_seq_pkg SHALL hold the FSM state enum and the triangle-map function.
REQ-037 Sub-module duty_tick_gen SHALL implement the STEP_TICKS down-counter (load, enable, terminal-count pulse).
REQ-038 The channel phase SHALL be computed by an accumulator stepped by PHASE_OFFSET per accept, not by a multiplier.

Verification
Bench parameters: NB_OUTPUTS=4, STEP_TICKS=10, STEP=64, PHASE_OFFSET=128.
REQ-039 Scenario: reset release, run=1, duty_ready=1 -> first frame words (idx,duty) = (0,0),(1,128),(2,255),(3,127) in 4 consecutive cycles, then one frame_done pulse.
REQ-040 Scenario: continue running -> after 10 WAIT cycles the second frame = (0,64),(1,192),(2,191),(3,63).
REQ-041 Scenario: duty_ready low for 3 cycles on index 1 -> word (1,128) held stable for 4 cycles, with no skipped or duplicated index.
REQ-042 Scenario: run dropped during the SEND of index 2 -> indices 2 and 3 still issued, frame_done pulses, then IDLE with busy=0; re-raising run gives frame P=64.
REQ-043 Scenario: rst asserted on the cycle index 1 is presented -> all outputs 0 in the same cycle; after release and run=1, the frame restarts at P=0.
REQ-044 Scenario: run for 8 frames -> P wraps 448 to 0 (512 wrap), and the 9th frame equals the 1st.

Source files
------------

// File: rtl/duty_seq_pkg.sv
// Shared types and helpers for the duty sequencer.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package duty_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Triangle map of a (dw+1)-bit phase: rising ramp in the lower half,
   // falling ramp (bitwise inverse) in the upper half.
   function automatic logic [31:0] triangle_map(input logic [32:0] q, input int dw);
      logic [31:0] mask;
      logic [31:0] low;
      mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
      low  = q[31:0] & mask;
      return q[dw] ? (~low & mask) : low;
   endfunction

endpackage

// File: rtl/duty_tick_gen.sv
// Frame-spacing down-counter: load to TICKS-1, count while enabled, flag zero.
// Latency: tc asserts combinationally in the TICKS-th enabled cycle after load.
// Backpressure: none; enable simply freezes the count when low.
module duty_tick_gen #(
   parameter int TICKS = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(TICKS);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TICKS - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: reload on request, otherwise decrement toward zero while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register, cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = en && !load && (cnt_q == '0);

endmodule

// File: rtl/duty_sequencer.sv
// Issues one triangle-mapped duty word per PWM channel per frame, frames spaced by STEP_TICKS.
// Latency: first word valid the cycle after run is sampled; one word per accepted cycle.
// Backpressure: valid/ready; word and index hold while duty_ready is low.
module duty_sequencer
   import duty_seq_pkg::*;
#(
   parameter int NB_OUTPUTS   = 16,
   parameter int DUTY_WIDTH   = 8,
   parameter int STEP_TICKS   = 100000,
   parameter int STEP         = 4,
   parameter int PHASE_OFFSET = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          run,
   input  logic                          duty_ready,
   output logic [DUTY_WIDTH-1:0]         duty_cycle,
   output logic [$clog2(NB_OUTPUTS)-1:0] duty_output,
   output logic                          duty_valid,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int IW = $clog2(NB_OUTPUTS);
   localparam int PW = DUTY_WIDTH + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB_OUTPUTS - 1);
   localparam logic [PW-1:0] STEP_W   = PW'(STEP);
   localparam logic [PW-1:0] OFF_W    = PW'(PHASE_OFFSET);

   state_t                state_q, state_d;
   logic [PW-1:0]         phase_q, phase_d;
   logic [PW-1:0]         chph_q, chph_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DUTY_WIDTH-1:0] duty_q, duty_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic          accept;
   logic          last_acc;
   logic          tick_load;
   logic          tick_en;
   logic          tick_tc;
   logic [PW-1:0] nxt_ch;
   logic [PW-1:0] nxt_frame;

   assign accept    = (state_q == ST_SEND) && valid_q && duty_ready;
   assign last_acc  = accept && (idx_q == LAST_IDX);
   assign tick_load = last_acc && run;
   assign tick_en   = (state_q == ST_WAIT);
   assign nxt_ch    = chph_q + OFF_W;
   assign nxt_frame = phase_q + STEP_W;

   duty_tick_gen #(
      .TICKS (STEP_TICKS)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .load (tick_load),
      .en   (tick_en),
      .tc   (tick_tc)
   );

   // FSM next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      chph_d  = chph_q;
      idx_d   = idx_q;
      duty_d  = duty_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_SEND;
               idx_d   = '0;
               chph_d  = phase_q;
               duty_d  = DUTY_WIDTH'(triangle_map(33'(phase_q), DUTY_WIDTH));
               valid_d = 1'b1;
            end
         end
         ST_SEND: begin
            if (last_acc) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = run ? ST_WAIT : ST_IDLE;
            end else if (accept) begin
               idx_d  = idx_q + 1'b1;
               chph_d = nxt_ch;
               duty_d = DUTY_WIDTH'(triangle_map(33'(nxt_ch), DUTY_WIDTH));
            end
         end
         ST_WAIT: begin
            if (!run) begin
               state_d = ST_IDLE;
            end else if (tick_tc) begin
               state_d = ST_SEND;
               phase_d = nxt_frame;
               idx_d   = '0;
               chph_d  = nxt_frame;
               duty_d  = DUTY_WIDTH'(triangle_map(33'(nxt_frame), DUTY_WIDTH));
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset clears everything and drops valid at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         chph_q  <= '0;
         idx_q   <= '0;
         duty_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         chph_q  <= chph_d;
         idx_q   <= idx_d;
         duty_q  <= duty_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign duty_cycle  = duty_q;
   assign duty_output = idx_q;
   assign duty_valid  = valid_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;

endmodule

// File: tb/tb_duty_sequencer.sv
// Directed bench for duty_sequencer: table of per-cycle vectors plus hand sequences.
// Inputs change 1 time unit after a rising edge; outputs sampled at that same point.
// Backpressure exercised by holding duty_ready low mid-frame.
module tb_duty_sequencer;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int TICKS = 10;
   localparam int STEPV = 64;
   localparam int OFF   = 128;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic       duty_ready = 1'b0;
   logic [7:0] duty_cycle;
   logic [1:0] duty_output;
   logic       duty_valid;
   logic       busy;
   logic       frame_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   duty_sequencer #(
      .NB_OUTPUTS   (N),
      .DUTY_WIDTH   (DW),
      .STEP_TICKS   (TICKS),
      .STEP         (STEPV),
      .PHASE_OFFSET (OFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .duty_ready  (duty_ready),
      .duty_cycle  (duty_cycle),
      .duty_output (duty_output),
      .duty_valid  (duty_valid),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   typedef struct {
      logic       run;
      logic       rdy;
      logic       vld;
      logic [1:0] idx;
      logic [7:0] duty;
      logic       fd;
      logic       bsy;
   } vec_t;

   vec_t tbl[21];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic r, input logic rd);
      run        = r;
      duty_ready = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_word(input string name, input int idx, input int duty);
      chk({name, "_vld"}, int'(duty_valid), 1);
      chk({name, "_idx"}, int'(duty_output), idx);
      chk({name, "_duty"}, int'(duty_cycle), duty);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_vld"}, int'(duty_valid), 0);
      chk({name, "_idx"}, int'(duty_output), 0);
      chk({name, "_duty"}, int'(duty_cycle), 0);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_fd"}, int'(frame_done), 0);
   endtask

   // Reference: triangle map of (P + i*OFF) mod 512 for an 8-bit duty word.
   function automatic int model_duty(input int p, input int i);
      int q;
      q = (p + i * OFF) % 512;
      return (q >= 256) ? (255 - (q - 256)) : q;
   endfunction

   task automatic setv(input int k, input logic r, input logic rd, input logic v,
                       input int idx, input int duty, input logic fd, input logic b);
      tbl[k].run  = r;
      tbl[k].rdy  = rd;
      tbl[k].vld  = v;
      tbl[k].idx  = 2'(idx);
      tbl[k].duty = 8'(duty);
      tbl[k].fd   = fd;
      tbl[k].bsy  = b;
   endtask

   initial begin
      int frame0[4];
      int gap;
      int p;
      bit timed_out;
      frame0[0] = 0; frame0[1] = 128; frame0[2] = 255; frame0[3] = 127;

      // First frame from P=0, wait, second frame from P=64, then run drop in WAIT.
      setv(0, 1, 1, 1, 0, 0, 0, 1);
      setv(1, 1, 1, 1, 1, 128, 0, 1);
      setv(2, 1, 1, 1, 2, 255, 0, 1);
      setv(3, 1, 1, 1, 3, 127, 0, 1);
      setv(4, 1, 1, 0, 0, 0, 1, 1);
      for (int k = 5; k <= 13; k++) setv(k, 1, 1, 0, 0, 0, 0, 1);
      setv(14, 1, 1, 1, 0, 64, 0, 1);
      setv(15, 1, 1, 1, 1, 192, 0, 1);
      setv(16, 1, 1, 1, 2, 191, 0, 1);
      setv(17, 1, 1, 1, 3, 63, 0, 1);
      setv(18, 1, 1, 0, 0, 0, 1, 1);
      setv(19, 0, 1, 0, 0, 0, 0, 0);
      setv(20, 0, 1, 0, 0, 0, 0, 0);

      // Held in reset with run and ready high: everything stays zero.
      #1;
      chk_zero("rst_t0");
      tick(1, 1);
      tick(1, 1);
      chk_zero("rst_held");

      // Release between edges; the next edge is the first run sample.
      rst = 1'b1;
      for (int k = 0; k < 21; k++) begin
         tick(tbl[k].run, tbl[k].rdy);
         chk($sformatf("tbl%0d_vld", k), int'(duty_valid), int'(tbl[k].vld));
         chk($sformatf("tbl%0d_fd", k), int'(frame_done), int'(tbl[k].fd));
         chk($sformatf("tbl%0d_busy", k), int'(busy), int'(tbl[k].bsy));
         if (tbl[k].vld) begin
            chk($sformatf("tbl%0d_idx", k), int'(duty_output), int'(tbl[k].idx));
            chk($sformatf("tbl%0d_duty", k), int'(duty_cycle), int'(tbl[k].duty));
         end
      end

      // Restart from IDLE resumes at retained P=64; run drops while index 2 is presented.
      tick(1, 1); chk_word("drop_w0", 0, 64);
      tick(1, 1); chk_word("drop_w1", 1, 192);
      tick(1, 1); chk_word("drop_w2", 2, 191);
      tick(0, 1); chk_word("drop_w3", 3, 63);
      tick(0, 1);
      chk("drop_fd", int'(frame_done), 1);
      chk("drop_vld", int'(duty_valid), 0);
      chk("drop_busy", int'(busy), 0);
      tick(0, 1);
      chk("drop_fd_pulse", int'(frame_done), 0);
      chk("drop_idle_busy", int'(busy), 0);
      tick(1, 0); chk_word("rerun_w0", 0, 64);
      chk("rerun_busy", int'(busy), 1);
      tick(1, 1); chk_word("rerun_w1", 1, 192);

      // Reset asserted while index 1 is presented: outputs clear without an edge.
      rst = 1'b0;
      #1;
      chk_zero("midrst_now");
      tick(1, 1);
      chk_zero("midrst_held");
      rst = 1'b1;

      // Restart from P=0, with ready low for 3 cycles on index 1.
      tick(1, 1); chk_word("rs_w0", 0, 0);
      tick(1, 1); chk_word("rs_w1", 1, 128);
      for (int s = 0; s < 3; s++) begin
         tick(1, 0);
         chk_word($sformatf("stall%0d", s), 1, 128);
      end
      tick(1, 1); chk_word("rs_w2", 2, 255);
      tick(1, 1); chk_word("rs_w3", 3, 127);
      tick(1, 1);
      chk("rs_fd", int'(frame_done), 1);
      chk("rs_vld", int'(duty_valid), 0);

      // Eight more frames: P steps by 64 and wraps 448 -> 0.
      timed_out = 1'b0;
      for (int f = 1; f <= 8 && !timed_out; f++) begin
         p   = (f * STEPV) % 512;
         gap = 1;
         for (int c = 0; c < 50 && !duty_valid; c++) begin
            tick(1, 1);
            if (!duty_valid) gap++;
         end
         if (!duty_valid) begin
            chk($sformatf("f%0d_timeout", f), 0, 1);
            timed_out = 1'b1;
         end else begin
            chk($sformatf("f%0d_gap", f), gap, TICKS);
            for (int i = 0; i < N; i++) begin
               chk_word($sformatf("f%0d_w%0d", f, i), i, model_duty(p, i));
               if (f == 8) chk($sformatf("wrap_w%0d", i), int'(duty_cycle), frame0[i]);
               tick(1, 1);
            end
            chk($sformatf("f%0d_fd", f), int'(frame_done), 1);
         end
      end

      tick(0, 0);
      chk("end_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
